// File: rtl/fb_write_arbiter_if.sv
// Frame-buffer write-port bundle: command/fill requests in, RAM write port out.
// The arbiter takes the slave view; the requester/RAM side takes the master view.
interface fb_write_arbiter_if #(
   parameter int AW = 12
);
   logic          cmd_req;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_data;
   logic          cmd_ack;
   logic          fill_start;
   logic [7:0]    fill_data;
   logic          fill_busy;
   logic          fill_done;
   logic [AW-1:0] ram_address;
   logic [7:0]    ram_data_out;
   logic          ram_write_enable;
   logic          ram_clk_enable;

   modport master (
      output cmd_req, cmd_addr, cmd_data, fill_start, fill_data,
      input  cmd_ack, fill_busy, fill_done,
      input  ram_address, ram_data_out, ram_write_enable, ram_clk_enable
   );

   modport slave (
      input  cmd_req, cmd_addr, cmd_data, fill_start, fill_data,
      output cmd_ack, fill_busy, fill_done,
      output ram_address, ram_data_out, ram_write_enable, ram_clk_enable
   );
endinterface

// File: rtl/fb_write_arbiter.sv
// Frame-buffer RAM write-port owner: round-robin between line-loader writes and
// a fill engine that floods every address with one byte.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | no strobe; grant pending cmd/fill (rr pointer on a tie)
//   S_WRITE | strobes held WR_HOLD cycles; ack / fill advance on last
module fb_write_arbiter #(
   parameter int PIXEL_WIDTH     = 64,
   parameter int PIXEL_HEIGHT    = 32,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int WR_HOLD         = 2
) (
   input logic               clk_in,
   input logic               reset_n,
   fb_write_arbiter_if.slave bus
);
   localparam int AW    = $clog2(PIXEL_HEIGHT) + $clog2(PIXEL_WIDTH * BYTES_PER_PIXEL);
   localparam int DEPTH = 2 ** AW;
   localparam int HCW   = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t          state_q, state_d;
   logic            grant_fill_q;
   logic            rr_fill_q;
   logic [HCW-1:0]  hold_q;
   logic [AW-1:0]   fill_cnt_q;
   logic [7:0]      fill_byte_q;
   logic            fill_busy_q;
   logic            fill_done_q;
   logic [AW-1:0]   addr_q;
   logic [7:0]      data_q;

   logic grant;
   logic pick_fill;
   logic last_hold;
   logic fill_last;
   logic fill_accept;

   assign grant       = (state_q == S_IDLE) && (bus.cmd_req || fill_busy_q);
   assign pick_fill   = fill_busy_q && (!bus.cmd_req || rr_fill_q);
   assign last_hold   = (state_q == S_WRITE) && (hold_q == '0);
   assign fill_last   = last_hold && grant_fill_q && (fill_cnt_q == AW'(DEPTH - 1));
   // fill_busy_q is still high during the final fill write, so a start there is dropped
   assign fill_accept = bus.fill_start && !fill_busy_q;

   always_ff @(posedge clk_in) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant)     state_d = S_WRITE;
         S_WRITE: if (last_hold) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ram_write_enable = (state_q == S_WRITE);
      bus.ram_clk_enable   = (state_q == S_WRITE);
      bus.cmd_ack          = last_hold && !grant_fill_q;
      bus.fill_busy        = fill_busy_q;
      bus.fill_done        = fill_done_q;
      bus.ram_address      = addr_q;
      bus.ram_data_out     = data_q;
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         grant_fill_q <= 1'b0;
         rr_fill_q    <= 1'b0;
         hold_q       <= '0;
         fill_cnt_q   <= '0;
         fill_byte_q  <= '0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         fill_done_q <= fill_last;

         if (grant) begin
            grant_fill_q <= pick_fill;
            rr_fill_q    <= !pick_fill;
            hold_q       <= HCW'(WR_HOLD - 1);
            addr_q       <= pick_fill ? fill_cnt_q  : bus.cmd_addr;
            data_q       <= pick_fill ? fill_byte_q : bus.cmd_data;
         end else if ((state_q == S_WRITE) && (hold_q != '0)) begin
            hold_q <= hold_q - HCW'(1);
         end

         if (fill_accept) begin
            fill_byte_q <= bus.fill_data;
            fill_cnt_q  <= '0;
            fill_busy_q <= 1'b1;
         end else if (last_hold && grant_fill_q) begin
            fill_cnt_q <= fill_cnt_q + AW'(1);
            if (fill_last) fill_busy_q <= 1'b0;
         end
      end
   end
endmodule
